rs_syndrome_calc: RTL and testbench

- Streaming Reed-Solomon syndrome generator for the C1 stage of the CD CIRC decoder.
- Consumes one 8-bit received symbol per accepted beat and accumulates N_SYN syndromes over an N_SYM-symbol frame using Horner's rule in GF(2^8), with field polynomial 0x11D and alpha = 0x02.
- Sits downstream of the frame/symbol deframer and upstream of the error locator/corrector.
- Presents one packed syndrome word per frame with a valid/ready handshake.

---
 rtl/cd_dec_pkg.sv | 24 ++
 rtl/gf256_mult.sv | 23 ++
 rtl/rs_syndrome_calc.sv | 129 ++++++++++++
 tb/tb_rs_syndrome_calc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cd_dec_pkg.sv
// Shared CD CIRC decoder definitions: GF(2^8) field constants, code sizes, syndrome FSM states.
// Combinational helpers only; no latency or flow control.
package cd_dec_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1D;
    localparam logic [7:0] GF_ALPHA = 8'h02;

    localparam int C1_N = 32;
    localparam int C1_K = 28;
    localparam int C2_N = 28;
    localparam int C2_K = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Multiply by alpha: shift left and fold x^8 back in through the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(2^8) multiplier, field polynomial 0x11D.
// Zero latency; no flow control.
module gf256_mult (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    import cd_dec_pkg::*;

    logic [7:0] acc;
    logic [7:0] sh;

    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        p = acc;
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome generator (Horner in GF(2^8)); syn_valid the cycle after the last accept.
// in_ready drops while a syndrome word is held; the word stays stable until syn_ready.
module rs_syndrome_calc #(
    parameter int N_SYM = 32,
    parameter int N_SYN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               syn_valid,
    input  logic               syn_ready,
    output logic [8*N_SYN-1:0] syn_data,
    output logic               syn_zero,
    output logic               frame_err
);
    import cd_dec_pkg::*;

    localparam int             CW         = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam logic [CW-1:0]  LAST       = CW'(N_SYM - 1);
    localparam logic [CW-1:0]  ONE        = CW'(1);
    localparam bit             SOF_CLOSES = (N_SYM == 2);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    syn  [N_SYN];
    logic [7:0]    prod [N_SYN];
    logic [7:0]    upd  [N_SYN];
    logic          accept;
    logic          last_beat;
    logic          load;
    logic          step;
    logic          close;
    logic          abort;
    logic          upd_zero;

    assign in_ready  = (state != HOLD);
    assign syn_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    // A sof beat only closes a frame when the frame is two symbols long.
    assign last_beat = (cnt == LAST) && (!in_sof || SOF_CLOSES);

    for (genvar j = 0; j < N_SYN; j++) begin : g_lane
        if (j == 0) begin : g_bypass
            assign prod[j] = syn[j];
        end else begin : g_mult
            localparam logic [7:0] ALPHA_J = 8'(1 << j);
            gf256_mult u_mult (
                .a (syn[j]),
                .b (ALPHA_J),
                .p (prod[j])
            );
        end
        assign upd[j]             = prod[j] ^ in_data;
        assign syn_data[8*j +: 8] = syn[j];
    end

    always_comb begin
        upd_zero = 1'b1;
        for (int j = 0; j < N_SYN; j++) begin
            if (upd[j] != 8'h00) upd_zero = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        close     = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_sof) begin
                    load      = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        step      = 1'b1;
                        close     = 1'b1;
                        state_nxt = HOLD;
                    end else if (in_sof) begin
                        load  = 1'b1;
                        abort = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (syn_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            syn_zero  <= 1'b0;
            for (int j = 0; j < N_SYN; j++) syn[j] <= 8'h00;
        end else begin
            frame_err <= abort;
            if (load) begin
                cnt <= ONE;
                for (int j = 0; j < N_SYN; j++) syn[j] <= in_data;
            end else if (step) begin
                cnt <= close ? '0 : cnt + ONE;
                for (int j = 0; j < N_SYN; j++) syn[j] <= upd[j];
                if (close) syn_zero <= upd_zero;
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc with hand-computed syndromes (N_SYM=32, N_SYN=4).
module tb_rs_syndrome_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        syn_valid;
    logic        syn_ready;
    logic [31:0] syn_data;
    logic        syn_zero;
    logic        frame_err;

    int cks = 0;
    int errs = 0;
    int fe_count = 0;
    logic [7:0] fbuf [32];

    rs_syndrome_calc #(.N_SYM(32), .N_SYN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_data  (syn_data),
        .syn_zero  (syn_zero),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_buf;
        for (int i = 0; i < 32; i++) fbuf[i] = 8'h00;
    endtask

    // Called at a negedge; returns at the negedge after the last symbol's edge.
    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 32; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_data  = fbuf[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic handshake;
        syn_ready = 1'b1;
        @(negedge clk);
        syn_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; syn_ready = 1'b0;
        #12;
        cks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        cks++; if (syn_valid !== 1'b0) begin errs++; $display("FAIL reset_syn_valid: got %b expected 0", syn_valid); end
        cks++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        cks++; if (syn_data !== 32'h0) begin errs++; $display("FAIL reset_syn_data: got %h expected 00000000", syn_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_frame;
        clear_buf();
        send_frame(1'b0);
        cks++; if (syn_valid !== 1'b1) begin errs++; $display("FAIL zero_latency: got syn_valid %b expected 1", syn_valid); end
        cks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL zero_in_ready: got %b expected 0", in_ready); end
        cks++; if (syn_data !== 32'h00000000) begin errs++; $display("FAIL zero_data: got %h expected 00000000", syn_data); end
        cks++; if (syn_zero !== 1'b1) begin errs++; $display("FAIL zero_flag: got %b expected 1", syn_zero); end
        handshake();
        cks++; if (syn_valid !== 1'b0) begin errs++; $display("FAIL zero_release: got syn_valid %b expected 0", syn_valid); end
        cks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL zero_ready_back: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_error;
        clear_buf(); fbuf[31] = 8'h05;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'h05050505) begin errs++; $display("FAIL last_sym_data: got %h expected 05050505", syn_data); end
        cks++; if (syn_zero !== 1'b0) begin errs++; $display("FAIL last_sym_zero: got %b expected 0", syn_zero); end
        handshake();

        clear_buf(); fbuf[30] = 8'h01;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'h08040201) begin errs++; $display("FAIL second_last_data: got %h expected 08040201", syn_data); end
        handshake();

        clear_buf(); fbuf[27] = 8'h01;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'hCD1D1001) begin errs++; $display("FAIL reduce_data: got %h expected cd1d1001", syn_data); end
        handshake();
    endtask

    task automatic test_backpressure;
        clear_buf(); fbuf[31] = 8'h05; fbuf[30] = 8'h01;
        send_frame(1'b1);
        cks++; if (syn_valid !== 1'b1) begin errs++; $display("FAIL bp_valid: got %b expected 1", syn_valid); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sof = 1'b1; in_data = 8'hFF;
            cks++; if (syn_data !== 32'h0D010704) begin errs++; $display("FAIL bp_hold_data: cycle %0d got %h expected 0d010704", c, syn_data); end
            cks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready); end
            cks++; if (syn_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", c, syn_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        handshake();
    endtask

    task automatic test_back_to_back;
        clear_buf(); fbuf[31] = 8'h05;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'h05050505) begin errs++; $display("FAIL b2b_data: got %h expected 05050505", syn_data); end
        handshake();
        clear_buf(); fbuf[30] = 8'h01;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'h08040201) begin errs++; $display("FAIL b2b_second_data: got %h expected 08040201", syn_data); end
        handshake();
    endtask

    task automatic test_abort;
        fe_count = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sof = (i == 0); in_data = 8'hAA;
            @(negedge clk);
        end
        clear_buf(); fbuf[29] = 8'h01;
        send_frame(1'b0);
        cks++; if (fe_count !== 1) begin errs++; $display("FAIL abort_pulses: got %0d expected 1", fe_count); end
        cks++; if (syn_valid !== 1'b1) begin errs++; $display("FAIL abort_valid: got %b expected 1", syn_valid); end
        cks++; if (syn_data !== 32'h40100401) begin errs++; $display("FAIL abort_data: got %h expected 40100401", syn_data); end
        cks++; if (frame_err !== 1'b0) begin errs++; $display("FAIL abort_pulse_len: got %b expected 0", frame_err); end
        handshake();
    endtask

    task automatic test_reset_midframe;
        fe_count = 0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_sof = (i == 0); in_data = 8'h33;
            @(negedge clk);
        end
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        cks++; if (syn_data !== 32'h0) begin errs++; $display("FAIL midrst_data: got %h expected 00000000", syn_data); end
        cks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        cks++; if (syn_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b expected 0", syn_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sof = 1'b0; in_data = 8'hFF;
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = 8'h00;
        cks++; if (syn_data !== 32'h0) begin errs++; $display("FAIL idle_drop_data: got %h expected 00000000", syn_data); end
        cks++; if (syn_valid !== 1'b0) begin errs++; $display("FAIL idle_drop_valid: got %b expected 0", syn_valid); end
        clear_buf(); fbuf[31] = 8'h05;
        send_frame(1'b0);
        cks++; if (syn_data !== 32'h05050505) begin errs++; $display("FAIL post_rst_data: got %h expected 05050505", syn_data); end
        cks++; if (fe_count !== 0) begin errs++; $display("FAIL midrst_frame_err: got %0d expected 0", fe_count); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_error();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", cks, errs);
        $finish;
    end

endmodule
